multi_zone_irrigation_ctrl: RTL and testbench

Parametrised successor to the single-zone pump controller. It accepts irrigation-time requests for NUM_ZONES zones and serves them one at a time, round-robin, through one shared pump and per-zone valves. Each zone is watered for a countdown of seconds derived from a prescaled tick. The block sits between the fuzzy decision stage(s), which supply req_valid/req_time, and the pump relay, valves and LCD status.

---
 rtl/multi_zone_irrigation_ctrl.sv | 131 +++++++++++++
 tb/tb_multi_zone_irrigation_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_zone_irrigation_ctrl.sv
// multi_zone_irrigation_ctrl: round-robin multi-zone irrigation scheduler driving one shared pump and per-zone valves
module multi_zone_irrigation_ctrl #(
  parameter int NUM_ZONES = 4,
  parameter int TIME_W = 8,
  parameter int TICK_DIV = 50,
  parameter int MIN_GAP = 2,
  localparam int ZW = NUM_ZONES > 1 ? $clog2(NUM_ZONES) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_ZONES-1:0]          req_valid,
  input  logic [NUM_ZONES*TIME_W-1:0]   req_time,
  output logic [NUM_ZONES-1:0]          req_ready,
  input  logic                          rain_present,
  input  logic                          abort,
  output logic                          pump_on,
  output logic [NUM_ZONES-1:0]          valve_on,
  output logic [ZW-1:0]                 active_zone,
  output logic [TIME_W-1:0]             watering_timer,
  output logic                          watering_in_progress,
  output logic                          sensor_enable,
  output logic [NUM_ZONES-1:0]          done_pulse
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int GW = MIN_GAP > 0 ? $clog2(MIN_GAP + 1) : 1;
  typedef enum logic [1:0] {IDLE, WATER, GAP} state_t;
  state_t state, state_n;
  logic [PW-1:0] presc;
  logic tick, water_n;
  logic [NUM_ZONES-1:0] pend, pend_n, acc, done_n, valve_n;
  logic [NUM_ZONES-1:0][TIME_W-1:0] pend_time, time_n;
  logic [ZW-1:0] rr, rr_n, sel, zone_n;
  logic [TIME_W-1:0] timer_n;
  logic [GW-1:0] gap, gap_n;
  assign tick = presc == PW'(TICK_DIV - 1);
  assign water_n = state_n == WATER;
  assign valve_n = water_n ? NUM_ZONES'(1) << zone_n : '0;
  // first pending zone at or after the round-robin pointer, wrapping
  always_comb begin
    sel = '0;
    for (int k = NUM_ZONES - 1; k >= 0; k--)
      if (pend[ZW'((int'(rr) + k) % NUM_ZONES)]) sel = ZW'((int'(rr) + k) % NUM_ZONES);
  end
  // request capture and next-state: abort beats rain beats tick beats accept
  always_comb begin
    state_n = state;
    pend_n = pend;
    time_n = pend_time;
    rr_n = rr;
    zone_n = active_zone;
    timer_n = watering_timer;
    gap_n = gap;
    done_n = '0;
    acc = '0;
    for (int i = 0; i < NUM_ZONES; i++) begin
      acc[i] = req_valid[i] & req_ready[i] & (|req_time[i*TIME_W +: TIME_W]);
      if (acc[i]) begin
        pend_n[i] = 1'b1;
        time_n[i] = req_time[i*TIME_W +: TIME_W];
      end
    end
    if (abort) begin
      state_n = IDLE;
      pend_n = '0;
      timer_n = '0;
    end else begin
      case (state)
        IDLE:
          if (|pend && !rain_present) begin
            state_n = WATER;
            zone_n = sel;
            timer_n = pend_time[sel];
            pend_n[sel] = 1'b0;
          end
        WATER:
          if (rain_present) begin
            state_n = IDLE;
            timer_n = '0;
          end else if (tick) begin
            timer_n = watering_timer - 1'b1;
            if (watering_timer == TIME_W'(1)) begin
              done_n[active_zone] = 1'b1;
              rr_n = (active_zone == ZW'(NUM_ZONES - 1)) ? '0 : active_zone + 1'b1;
              state_n = MIN_GAP == 0 ? IDLE : GAP;
              gap_n = GW'(MIN_GAP);
            end
          end
        GAP:
          if (tick) begin
            gap_n = gap - 1'b1;
            if (gap == GW'(1)) state_n = IDLE;
          end
        default: state_n = IDLE;
      endcase
    end
  end
  // state, prescaler and registered outputs derived from next-state values
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      presc <= '0;
      pend <= '0;
      pend_time <= '0;
      rr <= '0;
      gap <= '0;
      pump_on <= 1'b0;
      valve_on <= '0;
      active_zone <= '0;
      watering_timer <= '0;
      watering_in_progress <= 1'b0;
      sensor_enable <= 1'b1;
      done_pulse <= '0;
      req_ready <= '1;
    end else begin
      state <= state_n;
      presc <= tick ? '0 : presc + 1'b1;
      pend <= pend_n;
      pend_time <= time_n;
      rr <= rr_n;
      gap <= gap_n;
      pump_on <= water_n;
      valve_on <= valve_n;
      active_zone <= zone_n;
      watering_timer <= timer_n;
      watering_in_progress <= water_n;
      sensor_enable <= !water_n;
      done_pulse <= done_n;
      req_ready <= ~pend_n & ~valve_n;
    end
  end
endmodule

// File: tb/tb_multi_zone_irrigation_ctrl.sv
// tb_multi_zone_irrigation_ctrl: directed vector table plus multi-cycle sequences for the irrigation scheduler
module tb_multi_zone_irrigation_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] req_valid = '0;
  logic [31:0] req_time = '0;
  logic [3:0] req_ready;
  logic rain_present = 1'b0;
  logic abort = 1'b0;
  logic pump_on;
  logic [3:0] valve_on;
  logic [1:0] active_zone;
  logic [7:0] watering_timer;
  logic watering_in_progress;
  logic sensor_enable;
  logic [3:0] done_pulse;
  int n_tests = 0;
  int n_fail = 0;

  multi_zone_irrigation_ctrl #(.NUM_ZONES(4), .TIME_W(8), .TICK_DIV(4), .MIN_GAP(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_time(req_time), .req_ready(req_ready),
    .rain_present(rain_present), .abort(abort), .pump_on(pump_on), .valve_on(valve_on),
    .active_zone(active_zone), .watering_timer(watering_timer),
    .watering_in_progress(watering_in_progress), .sensor_enable(sensor_enable), .done_pulse(done_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic rst;
    logic [3:0] rv;
    logic [31:0] rt;
    logic rain;
    logic ab;
    logic [7:0] n;
    logic pump;
    logic [3:0] valve;
    logic [1:0] zone;
    logic [7:0] timer;
    logic [3:0] done;
    logic [3:0] ready;
    logic sens;
    logic wip;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int rst, int rv, int rt, int rain, int ab, int n,
                              int pump, int valve, int zone, int timer, int done, int ready, int sens, int wip);
    vec_t v;
    v.rst = rst[0]; v.rv = rv[3:0]; v.rt = rt; v.rain = rain[0]; v.ab = ab[0]; v.n = n[7:0];
    v.pump = pump[0]; v.valve = valve[3:0]; v.zone = zone[1:0]; v.timer = timer[7:0];
    v.done = done[3:0]; v.ready = ready[3:0]; v.sens = sens[0]; v.wip = wip[0];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] rv, input logic [31:0] rt);
    req_valid = rv;
    req_time = rt;
  endtask

  task automatic do_reset();
    drive(4'h0, 32'h0);
    rain_present = 1'b0;
    abort = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_pump(input logic lvl, input int lim, output int cyc);
    cyc = 0;
    while (pump_on !== lvl && cyc < lim) begin
      step();
      cyc++;
    end
    chk("wait_pump", {31'b0, pump_on}, {31'b0, lvl});
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, " pump"}, pump_on, 0);
    chk({nm, " valve"}, valve_on, 0);
    chk({nm, " zone"}, active_zone, 0);
    chk({nm, " timer"}, watering_timer, 0);
    chk({nm, " wip"}, watering_in_progress, 0);
    chk({nm, " sensor"}, sensor_enable, 1);
    chk({nm, " done"}, done_pulse, 0);
    chk({nm, " ready"}, req_ready, 4'hF);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    vec_t v;
    int order[$];
    int dn[4];
    int fall;
    logic prev;
    // single-zone flow, zero-time and duplicate requests during GAP, prescaler phase fixed by reset
    tbl.push_back(mk(1, 'h0, 'h0,        0, 0, 2, 0, 'h0, 0, 0, 'h0, 'hF, 1, 0));
    tbl.push_back(mk(0, 'h2, 'h300,      0, 0, 1, 0, 'h0, 0, 0, 'h0, 'hD, 1, 0));
    tbl.push_back(mk(0, 'h0, 'h0,        0, 0, 1, 1, 'h2, 1, 3, 'h0, 'hD, 0, 1));
    tbl.push_back(mk(0, 'h0, 'h0,        0, 0, 2, 1, 'h2, 1, 2, 'h0, 'hD, 0, 1));
    tbl.push_back(mk(0, 'h0, 'h0,        0, 0, 3, 1, 'h2, 1, 2, 'h0, 'hD, 0, 1));
    tbl.push_back(mk(0, 'h0, 'h0,        0, 0, 1, 1, 'h2, 1, 1, 'h0, 'hD, 0, 1));
    tbl.push_back(mk(0, 'h0, 'h0,        0, 0, 3, 1, 'h2, 1, 1, 'h0, 'hD, 0, 1));
    tbl.push_back(mk(0, 'h0, 'h0,        0, 0, 1, 0, 'h0, 1, 0, 'h2, 'hF, 1, 0));
    tbl.push_back(mk(0, 'h0, 'h0,        0, 0, 1, 0, 'h0, 1, 0, 'h0, 'hF, 1, 0));
    tbl.push_back(mk(0, 'h8, 'h0,        0, 0, 1, 0, 'h0, 1, 0, 'h0, 'hF, 1, 0));
    tbl.push_back(mk(0, 'h4, 'h20000,    0, 0, 1, 0, 'h0, 1, 0, 'h0, 'hB, 1, 0));
    tbl.push_back(mk(0, 'h4, 'h70000,    0, 0, 1, 0, 'h0, 1, 0, 'h0, 'hB, 1, 0));
    tbl.push_back(mk(0, 'h0, 'h0,        0, 0, 4, 0, 'h0, 1, 0, 'h0, 'hB, 1, 0));
    tbl.push_back(mk(0, 'h0, 'h0,        0, 0, 1, 1, 'h4, 2, 2, 'h0, 'hB, 0, 1));
    tbl.push_back(mk(0, 'h0, 'h0,        0, 0, 3, 1, 'h4, 2, 1, 'h0, 'hB, 0, 1));
    tbl.push_back(mk(0, 'h0, 'h0,        0, 0, 4, 0, 'h0, 2, 0, 'h4, 'hF, 1, 0));
    tbl.push_back(mk(0, 'h0, 'h0,        0, 0, 1, 0, 'h0, 2, 0, 'h0, 'hF, 1, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      reset = v.rst;
      drive(v.rv, v.rt);
      rain_present = v.rain;
      abort = v.ab;
      repeat (v.n) step();
      chk($sformatf("v%0d pump", i), pump_on, v.pump);
      chk($sformatf("v%0d valve", i), valve_on, v.valve);
      chk($sformatf("v%0d zone", i), active_zone, v.zone);
      chk($sformatf("v%0d timer", i), watering_timer, v.timer);
      chk($sformatf("v%0d done", i), done_pulse, v.done);
      chk($sformatf("v%0d ready", i), req_ready, v.ready);
      chk($sformatf("v%0d sensor", i), sensor_enable, v.sens);
      chk($sformatf("v%0d wip", i), watering_in_progress, v.wip);
    end
    drive(4'h0, 32'h0);

    // three zones at once: round-robin order, two-tick gaps, one done pulse each
    do_reset();
    drive(4'hD, 32'h0101_0002);
    step();
    drive(4'h0, 32'h0);
    dn = '{0, 0, 0, 0};
    fall = -1;
    prev = 1'b0;
    for (int c = 0; c < 80; c++) begin
      step();
      chk("t2 onehot", {31'b0, $countones(valve_on) <= 1}, 1);
      chk("t2 pump_eq", pump_on, |valve_on);
      chk("t2 sensor", sensor_enable, !pump_on);
      for (int b = 0; b < 4; b++) if (done_pulse[b]) dn[b]++;
      if (pump_on && !prev) begin
        order.push_back(int'(active_zone));
        chk("t2 start_time", watering_timer, active_zone == 2'd0 ? 2 : 1);
        if (fall >= 0) chk("t2 gap", c - fall, 9);
      end
      if (!pump_on && prev) fall = c;
      prev = pump_on;
    end
    chk("t2 order_len", order.size(), 3);
    if (order.size() == 3) begin
      chk("t2 order0", order[0], 0);
      chk("t2 order1", order[1], 2);
      chk("t2 order2", order[2], 3);
    end
    for (int b = 0; b < 4; b++) chk($sformatf("t2 done_cnt%0d", b), dn[b], b == 1 ? 0 : 1);

    // rain during watering drops the active zone and keeps the other pending
    do_reset();
    drive(4'h5, 32'h0003_0005);
    step();
    drive(4'h0, 32'h0);
    wait_pump(1'b1, 10, cyc);
    chk("t3 zone", active_zone, 0);
    chk("t3 timer5", watering_timer, 5);
    rain_present = 1'b1;
    step();
    chk("t3 pump_off", pump_on, 0);
    chk("t3 valve_off", valve_on, 0);
    chk("t3 timer0", watering_timer, 0);
    chk("t3 no_done", done_pulse, 0);
    chk("t3 ready", req_ready, 4'hB);
    for (int c = 0; c < 10; c++) begin
      step();
      chk("t3 rain_pump", pump_on, 0);
      chk("t3 rain_done", done_pulse, 0);
    end
    chk("t3 ready_hold", req_ready, 4'hB);
    rain_present = 1'b0;
    wait_pump(1'b1, 2, cyc);
    chk("t3 resume_zone", active_zone, 2);
    chk("t3 resume_time", watering_timer, 3);

    // abort clears pending work and drops a same-cycle request
    do_reset();
    drive(4'hE, 32'h0303_0400);
    step();
    drive(4'h0, 32'h0);
    wait_pump(1'b1, 10, cyc);
    chk("t4 zone", active_zone, 1);
    step();
    step();
    abort = 1'b1;
    drive(4'h1, 32'h0000_0009);
    step();
    abort = 1'b0;
    drive(4'h0, 32'h0);
    chk("t4 pump", pump_on, 0);
    chk("t4 valve", valve_on, 0);
    chk("t4 timer", watering_timer, 0);
    chk("t4 ready", req_ready, 4'hF);
    chk("t4 done", done_pulse, 0);
    for (int c = 0; c < 20; c++) begin
      step();
      chk("t4 idle_pump", pump_on, 0);
      chk("t4 idle_done", done_pulse, 0);
      chk("t4 idle_ready", req_ready, 4'hF);
    end

    // reset mid-watering restores reset values and the round-robin pointer
    do_reset();
    drive(4'h4, 32'h0001_0000);
    step();
    drive(4'h0, 32'h0);
    wait_pump(1'b1, 10, cyc);
    wait_pump(1'b0, 20, cyc);
    drive(4'h8, 32'h0500_0000);
    step();
    drive(4'h0, 32'h0);
    wait_pump(1'b1, 40, cyc);
    chk("t6 zone3", active_zone, 3);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_reset_vals("t6 rst");
    drive(4'hA, 32'h0100_0100);
    step();
    drive(4'h0, 32'h0);
    wait_pump(1'b1, 10, cyc);
    chk("t6 rr_zone", active_zone, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
